// File: rtl/cfg_spc_pkg.sv
// Shared types and constants for the framed serial-to-parallel configuration register.
package cfg_spc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FULL  = 2'd2,
      OVER  = 2'd3
   } state_e;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_SHORT   = 2'b01;
   localparam logic [1:0] ERR_PARITY  = 2'b10;
   localparam logic [1:0] ERR_OVERRUN = 2'b11;

   localparam int unsigned BIT_CNT_W = 7;

   // Counter must hold 0..FRAME+1 (FRAME+1 marks overrun).
   function automatic int unsigned cnt_width(input int unsigned frame);
      return $clog2(frame + 2);
   endfunction

endpackage

// File: rtl/cfg_frame_ctrl.sv
// Frame control: saturating bit counter, frame state and Strobe evaluation.
module cfg_frame_ctrl
   import cfg_spc_pkg::*;
#(
   parameter int unsigned FRAME = 34
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 shift_en,
   input  logic                 strobe,
   input  logic                 parity_ok,
   output logic                 commit_c,
   output logic                 load_ok,
   output logic                 err,
   output logic [1:0]           err_code,
   output logic [BIT_CNT_W-1:0] bit_cnt
);

   localparam int unsigned CW = cnt_width(FRAME);
   localparam logic [CW-1:0] CNT_FULL = CW'(FRAME);
   localparam logic [CW-1:0] CNT_OVER = CW'(FRAME + 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          load_ok_q, load_ok_d;
   logic          err_q, err_d;
   logic [1:0]    code_q, code_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         load_ok_q <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= ERR_NONE;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         load_ok_q <= load_ok_d;
         err_q     <= err_d;
         code_q    <= code_d;
      end
   end

   // Strobe wins over shifting; every Strobe closes the frame.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      load_ok_d = 1'b0;
      err_d     = err_q;
      code_d    = code_q;
      commit_c  = 1'b0;
      if (strobe) begin
         state_d = IDLE;
         cnt_d   = '0;
         case (state_q)
            FULL: begin
               if (parity_ok) begin
                  commit_c  = 1'b1;
                  load_ok_d = 1'b1;
                  err_d     = 1'b0;
                  code_d    = ERR_NONE;
               end else begin
                  err_d  = 1'b1;
                  code_d = ERR_PARITY;
               end
            end
            OVER: begin
               err_d  = 1'b1;
               code_d = ERR_OVERRUN;
            end
            default: begin
               err_d  = 1'b1;
               code_d = ERR_SHORT;
            end
         endcase
      end else if (shift_en) begin
         if (cnt_q != CNT_OVER) begin
            cnt_d = cnt_q + CW'(1);
         end
         if (cnt_d == CNT_OVER) begin
            state_d = OVER;
         end else if (cnt_d == CNT_FULL) begin
            state_d = FULL;
         end else begin
            state_d = SHIFT;
         end
      end
   end

   assign load_ok  = load_ok_q;
   assign err      = err_q;
   assign err_code = code_q;
   assign bit_cnt  = BIT_CNT_W'(cnt_q);

endmodule

// File: rtl/cfg_spc_frame.sv
// Framed serial-to-parallel configuration register with shadow commit and daisy-chain output.
module cfg_spc_frame
   import cfg_spc_pkg::*;
#(
   parameter int unsigned      WIDTH     = 33,
   parameter bit               PARITY_EN = 1'b1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Cfg_in,
   input  logic                 Cfg_en,
   input  logic                 Strobe,
   output logic [WIDTH-1:0]     Cfg_out,
   output logic                 Cfg_sout,
   output logic                 Load_ok,
   output logic                 Err,
   output logic [1:0]           Err_code,
   output logic [BIT_CNT_W-1:0] Bit_cnt
);

   localparam int unsigned FRAME = WIDTH + (PARITY_EN ? 1 : 0);

   logic [FRAME-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] cfg_q, cfg_d;
   logic             sout_q, sout_d;
   logic             shift_en;
   logic             parity_ok;
   logic             commit_c;

   assign shift_en  = Cfg_en & ~Strobe;
   assign parity_ok = PARITY_EN ? ~(^shreg_q) : 1'b1;

   cfg_frame_ctrl #(
      .FRAME (FRAME)
   ) u_ctrl (
      .clk       (Clk),
      .rst       (Reset),
      .shift_en  (shift_en),
      .strobe    (Strobe),
      .parity_ok (parity_ok),
      .commit_c  (commit_c),
      .load_ok   (Load_ok),
      .err       (Err),
      .err_code  (Err_code),
      .bit_cnt   (Bit_cnt)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         shreg_q <= '0;
         cfg_q   <= RESET_VAL;
         sout_q  <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         cfg_q   <= cfg_d;
         sout_q  <= sout_d;
      end
   end

   // Shift right with the new bit entering at the MSB; works down to a 1-bit frame.
   always_comb begin
      shreg_d = shreg_q;
      sout_d  = sout_q;
      cfg_d   = cfg_q;
      if (shift_en) begin
         shreg_d = FRAME'({Cfg_in, shreg_q} >> 1);
         sout_d  = shreg_q[0];
      end
      if (commit_c) begin
         cfg_d = shreg_q[WIDTH-1:0];
      end
   end

   assign Cfg_out  = cfg_q;
   assign Cfg_sout = sout_q;

endmodule

// File: tb/tb_cfg_spc_frame.sv
// Directed bench: vector table on an 8-bit instance plus hand sequences and a two-instance chain.
module tb_cfg_spc_frame;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, din, en, stb;
   logic [7:0] out8;
   logic       sout8, ld8, err8;
   logic [1:0] code8;
   logic [6:0] cnt8;

   logic        c_in, en_a, en_b, stb_a, stb_b;
   logic [32:0] out_a, out_b;
   logic        sout_a, sout_b, ld_a, ld_b, err_a, err_b;
   logic [1:0]  code_a, code_b;
   logic [6:0]  cnt_a, cnt_b;

   cfg_spc_frame #(.WIDTH(8), .PARITY_EN(1'b1), .RESET_VAL(8'h5A)) dut8 (
      .Clk(clk), .Reset(rst), .Cfg_in(din), .Cfg_en(en), .Strobe(stb),
      .Cfg_out(out8), .Cfg_sout(sout8), .Load_ok(ld8), .Err(err8),
      .Err_code(code8), .Bit_cnt(cnt8));

   cfg_spc_frame #(.WIDTH(33), .PARITY_EN(1'b1)) dut_a (
      .Clk(clk), .Reset(rst), .Cfg_in(c_in), .Cfg_en(en_a), .Strobe(stb_a),
      .Cfg_out(out_a), .Cfg_sout(sout_a), .Load_ok(ld_a), .Err(err_a),
      .Err_code(code_a), .Bit_cnt(cnt_a));

   cfg_spc_frame #(.WIDTH(33), .PARITY_EN(1'b1)) dut_b (
      .Clk(clk), .Reset(rst), .Cfg_in(sout_a), .Cfg_en(en_b), .Strobe(stb_b),
      .Cfg_out(out_b), .Cfg_sout(sout_b), .Load_ok(ld_b), .Err(err_b),
      .Err_code(code_b), .Bit_cnt(cnt_b));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step8(input logic d, input logic e, input logic s);
      din = d; en = e; stb = s;
      @(posedge clk); #1;
      din = 1'b0; en = 1'b0; stb = 1'b0;
   endtask

   task automatic chain_step(input logic d, input logic ea, input logic eb,
                             input logic sa, input logic sb);
      c_in = d; en_a = ea; en_b = eb; stb_a = sa; stb_b = sb;
      @(posedge clk); #1;
      c_in = 1'b0; en_a = 1'b0; en_b = 1'b0; stb_a = 1'b0; stb_b = 1'b0;
   endtask

   typedef struct {
      int          nbits;
      logic [15:0] frame;
      logic [6:0]  exp_cnt;
      logic [7:0]  exp_out;
      logic        exp_err;
      logic [1:0]  exp_code;
      logic        exp_ld;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [8:0]  pat;
      logic [32:0] wa, wb;
      logic [33:0] fa, fb;

      // frame bits are sent LSB first; bit 8 is the parity bit
      vecs[0] = '{9,  16'h00A5, 7'd9,  8'hA5, 1'b0, 2'b00, 1'b1};
      vecs[1] = '{9,  16'h00A4, 7'd9,  8'hA5, 1'b1, 2'b10, 1'b0};
      vecs[2] = '{9,  16'h003C, 7'd9,  8'h3C, 1'b0, 2'b00, 1'b1};
      vecs[3] = '{5,  16'h001F, 7'd5,  8'h3C, 1'b1, 2'b01, 1'b0};
      vecs[4] = '{10, 16'h0155, 7'd10, 8'h3C, 1'b1, 2'b11, 1'b0};
      vecs[5] = '{12, 16'h0AAA, 7'd10, 8'h3C, 1'b1, 2'b11, 1'b0};
      vecs[6] = '{9,  16'h00FF, 7'd9,  8'hFF, 1'b0, 2'b00, 1'b1};
      vecs[7] = '{9,  16'h0101, 7'd9,  8'h01, 1'b0, 2'b00, 1'b1};

      rst = 1'b1; din = 1'b0; en = 1'b0; stb = 1'b0;
      c_in = 1'b0; en_a = 1'b0; en_b = 1'b0; stb_a = 1'b0; stb_b = 1'b0;
      #2;
      chk("reset_out", 64'(out8), 64'h5A);
      chk("reset_cnt", 64'(cnt8), 64'd0);
      chk("reset_err", 64'({err8, code8}), 64'd0);
      chk("reset_ld_sout", 64'({ld8, sout8}), 64'd0);
      chk("reset_chain_out", 64'(out_a), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         for (int b = 0; b < vecs[i].nbits; b++) step8(vecs[i].frame[b], 1'b1, 1'b0);
         chk($sformatf("vec%0d_cnt", i), 64'(cnt8), 64'(vecs[i].exp_cnt));
         step8(1'b0, 1'b0, 1'b1);
         chk($sformatf("vec%0d_out", i), 64'(out8), 64'(vecs[i].exp_out));
         chk($sformatf("vec%0d_err", i), 64'(err8), 64'(vecs[i].exp_err));
         chk($sformatf("vec%0d_code", i), 64'(code8), 64'(vecs[i].exp_code));
         chk($sformatf("vec%0d_ld", i), 64'(ld8), 64'(vecs[i].exp_ld));
         chk($sformatf("vec%0d_cnt0", i), 64'(cnt8), 64'd0);
         step8(1'b0, 1'b0, 1'b0);
         chk($sformatf("vec%0d_ld_off", i), 64'(ld8), 64'd0);
      end

      // Strobe together with Cfg_en after 8 bits: bit dropped, frame short
      for (int b = 0; b < 8; b++) step8(1'b1, 1'b1, 1'b0);
      chk("simul_cnt8", 64'(cnt8), 64'd8);
      step8(1'b1, 1'b1, 1'b1);
      chk("simul_code", 64'({err8, code8}), 64'({1'b1, 2'b01}));
      chk("simul_cnt", 64'(cnt8), 64'd0);
      chk("simul_out", 64'(out8), 64'h01);
      for (int b = 0; b < 3; b++) step8(1'b0, 1'b1, 1'b0);
      chk("sticky_err", 64'({err8, code8}), 64'({1'b1, 2'b01}));
      chk("sticky_cnt", 64'(cnt8), 64'd3);
      step8(1'b0, 1'b0, 1'b1);

      // Cfg_sout lags Cfg_in by 9 shifts
      pat = 9'h165;
      for (int b = 0; b < 9; b++) step8(pat[b], 1'b1, 1'b0);
      for (int b = 0; b < 9; b++) begin
         step8(1'b0, 1'b1, 1'b0);
         chk($sformatf("sout_lag%0d", b), 64'(sout8), 64'(pat[b]));
      end
      step8(1'b0, 1'b0, 1'b1);
      chk("over_code", 64'(code8), 64'd3);

      // Reset in the middle of a frame
      pat = 9'h03C;
      for (int b = 0; b < 9; b++) step8(pat[b], 1'b1, 1'b0);
      step8(1'b0, 1'b0, 1'b1);
      chk("pre_rst_out", 64'(out8), 64'h3C);
      step8(1'b1, 1'b1, 1'b0);
      step8(1'b1, 1'b1, 1'b0);
      step8(1'b0, 1'b0, 1'b1);
      chk("pre_rst_err", 64'(err8), 64'd1);
      for (int b = 0; b < 4; b++) step8(1'b1, 1'b1, 1'b0);
      chk("pre_rst_cnt", 64'(cnt8), 64'd4);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_out", 64'(out8), 64'h5A);
      chk("async_rst_cnt", 64'(cnt8), 64'd0);
      chk("async_rst_err", 64'({err8, code8}), 64'd0);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Daisy chain: far word goes through A first, then both shift together
      wb = 33'h0_1234_5678;
      wa = 33'h1_0ABC_DEF0;
      fb = {^wb, wb};
      fa = {^wa, wa};
      for (int i = 0; i < 34; i++) chain_step(fb[i], 1'b1, 1'b0, 1'b0, 1'b0);
      chain_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("chain_a_over", 64'(cnt_a), 64'd35);
      chain_step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("chain_a_overrun", 64'({err_a, code_a}), 64'({1'b1, 2'b11}));
      for (int i = 0; i < 34; i++) chain_step(fa[i], 1'b1, 1'b1, 1'b0, 1'b0);
      chk("chain_cnt", 64'({cnt_a, cnt_b}), 64'({7'd34, 7'd34}));
      chain_step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("chain_out_a", 64'(out_a), 64'(wa));
      chk("chain_out_b", 64'(out_b), 64'(wb));
      chk("chain_ld", 64'({ld_a, ld_b}), 64'd3);
      chk("chain_err", 64'({err_a, err_b}), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
